// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID pipeline register and
// saturating stall/flush event counters for performance debug.
module fetch_stage #(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter int unsigned          CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 PCwrite,
  input  logic                 IF_IDwrite,
  input  logic                 IF_flush,
  input  logic                 branch_i,
  input  logic [PC_WIDTH-1:0]  branch_target_i,
  input  logic                 jump_i,
  input  logic [PC_WIDTH-1:0]  jump_target_i,
  output logic [PC_WIDTH-1:0]  imem_addr_o,
  input  logic [31:0]          imem_data_i,
  output logic [PC_WIDTH-1:0]  IF_ID_pc_plus4_o,
  output logic [31:0]          IF_ID_instr_o,
  output logic                 IF_ID_valid_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  localparam logic [PC_WIDTH-1:0] PcStep = PC_WIDTH'(4);

  logic [PC_WIDTH-1:0]  pcQ, pcD, pcPlus4;
  logic [PC_WIDTH-1:0]  ifPcPlus4Q, ifPcPlus4D;
  logic [31:0]          ifInstrQ, ifInstrD;
  logic                 ifValidQ, ifValidD;
  logic [CNT_WIDTH-1:0] stallCntQ, stallCntD;
  logic [CNT_WIDTH-1:0] flushCntQ, flushCntD;
  logic                 stallEvent;

  // Wraps modulo 2^PC_WIDTH by construction.
  assign pcPlus4 = pcQ + PcStep;

  // Redirects take priority over a stall; the branch belongs to the older instruction.
  always_comb begin
    pcD = pcQ;
    if (branch_i) begin
      pcD = branch_target_i;
    end else if (jump_i) begin
      pcD = jump_target_i;
    end else if (PCwrite) begin
      pcD = pcPlus4;
    end
  end

  always_comb begin
    ifPcPlus4D = ifPcPlus4Q;
    ifInstrD   = ifInstrQ;
    ifValidD   = ifValidQ;
    if (IF_flush) begin
      ifPcPlus4D = '0;
      ifInstrD   = '0;
      ifValidD   = 1'b0;
    end else if (IF_IDwrite) begin
      ifPcPlus4D = pcPlus4;
      ifInstrD   = imem_data_i;
      ifValidD   = 1'b1;
    end
  end

  assign stallEvent = !IF_IDwrite && !IF_flush;

  always_comb begin
    stallCntD = stallCntQ;
    flushCntD = flushCntQ;
    if (stallEvent && (stallCntQ != '1)) begin
      stallCntD = stallCntQ + 1'b1;
    end
    if (IF_flush && (flushCntQ != '1)) begin
      flushCntD = flushCntQ + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pcQ        <= RESET_PC;
      ifPcPlus4Q <= '0;
      ifInstrQ   <= '0;
      ifValidQ   <= 1'b0;
      stallCntQ  <= '0;
      flushCntQ  <= '0;
    end else begin
      pcQ        <= pcD;
      ifPcPlus4Q <= ifPcPlus4D;
      ifInstrQ   <= ifInstrD;
      ifValidQ   <= ifValidD;
      stallCntQ  <= stallCntD;
      flushCntQ  <= flushCntD;
    end
  end

  assign imem_addr_o      = pcQ;
  assign IF_ID_pc_plus4_o = ifPcPlus4Q;
  assign IF_ID_instr_o    = ifInstrQ;
  assign IF_ID_valid_o    = ifValidQ;
  assign stall_cnt_o      = stallCntQ;
  assign flush_cnt_o      = flushCntQ;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline: holds the program counter, selects the next PC (sequential, taken branch, or jump), presents the fetch address to instruction memory, and captures the fetched word into the IF/ID pipeline register. It is the direct producer of the IF/ID register fields the hazard detection unit reads, and the consumer of that unit's PCwrite, IF_IDwrite and IF_flush controls. Two saturating event counters (stall cycles, flushes) are exposed for performance debug.

## Interface
- PC_WIDTH, 32, width of PC, targets and IF/ID pc field
- RESET_PC, 0, PC value loaded on reset
- CNT_WIDTH, 16, width of each event counter

- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- PCwrite  in  1  1 = PC may advance sequentially; 0 = hold (load-use stall)
- IF_IDwrite  in  1  1 = IF/ID register loads; 0 = hold
- IF_flush  in  1  1 = IF/ID register loads a bubble
- branch_i  in  1  taken branch resolved this cycle
- branch_target_i  in  PC_WIDTH  branch destination
- jump_i  in  1  jump decoded this cycle
- jump_target_i  in  PC_WIDTH  jump destination
- imem_addr_o  out  PC_WIDTH  fetch address (= current PC, combinational)
- imem_data_i  in  32  instruction word for imem_addr_o, same cycle
- IF_ID_pc_plus4_o  out  PC_WIDTH  registered PC+4 of captured instruction
- IF_ID_instr_o  out  32  registered instruction
- IF_ID_valid_o  out  1  1 = IF/ID holds a real instruction
- stall_cnt_o  out  CNT_WIDTH  cycles with IF/ID held
- flush_cnt_o  out  CNT_WIDTH  cycles with IF/ID flushed

## Operation
- Next-PC priority, evaluated every cycle: branch_i -> branch_target_i; else jump_i -> jump_target_i; else PCwrite=1 -> PC+4; else hold PC.
- Redirect overrides stall: branch_i or jump_i loads the target even when PCwrite=0.
- branch_i and jump_i both 1: branch wins (branch belongs to the older instruction).
- PC+4 wraps modulo 2^PC_WIDTH (max aligned PC + 4 -> 0); no overflow flag.
- Targets are loaded unmodified; low two bits are not forced or checked.
- IF/ID priority: IF_flush=1 -> bubble (instr 0x00000000, pc_plus4 0, valid 0); else IF_IDwrite=1 -> load {PC+4, imem_data_i, valid 1}; else hold all three fields.
- IF_flush=1 with IF_IDwrite=0: flush wins.
- stall_cnt_o increments when IF_IDwrite=0 and IF_flush=0; flush_cnt_o increments when IF_flush=1; both saturate at all-ones and never wrap.
- No handshake with imem; imem_data_i is sampled only at the clock edge.

## Timing
- Reset (rst_i=1, any time, clock not required): PC=RESET_PC, imem_addr_o=RESET_PC, IF_ID_pc_plus4_o=0, IF_ID_instr_o=0, IF_ID_valid_o=0, stall_cnt_o=0, flush_cnt_o=0. Mid-operation reset discards in-flight state immediately.
- First rising edge after rst_i falls: instruction at RESET_PC captured into IF/ID; PC becomes RESET_PC+4.
- Fetch-to-IF/ID latency: 1 cycle. Redirect-to-fetch latency: target appears on imem_addr_o the cycle after branch_i/jump_i is sampled.
- All control inputs are sampled at the rising edge only; glitches between edges have no effect.
- Load-use stall (PCwrite=0, IF_IDwrite=0) held N cycles: PC and IF/ID frozen N cycles, stall_cnt_o rises by N.

## Test plan
- Reset release, RESET_PC=0, PCwrite=IF_IDwrite=1, imem returns addr-indexed words -> imem_addr_o 0,4,8,12 on successive cycles; IF/ID shows pc_plus4 4,8,12 with matching instr, valid=1.
- PCwrite=0, IF_IDwrite=0 for 2 cycles at PC=0x10 -> imem_addr_o stays 0x10, IF/ID unchanged, stall_cnt_o=2, then fetch resumes at 0x14.
- branch_i=1, target 0x100, IF_flush=1, PCwrite=0 in same cycle -> next imem_addr_o=0x100, IF_ID_valid_o=0, instr=0, flush_cnt_o+1, stall_cnt_o unchanged.
- branch_i=1 (0x200) and jump_i=1 (0x300) together -> next PC=0x200.
- PC=0xFFFFFFFC sequential -> next PC 0x00000000, IF_ID_pc_plus4_o=0x00000000; force stall_cnt_o to 0xFFFF then one more stall -> stays 0xFFFF.
- Assert rst_i asynchronously mid-cycle during a stall -> all outputs reset values before next edge; counters 0.
